patch_step_sequencer: RTL

- Initiator for the three-patch node memory: the u0/u1/u2 store, 18-bit signed, 16 nodes per patch, registered read.
- On each start pulse it runs one finite-difference time step of a 16-node string with fixed ends. For every node it reads the current (u1) and previous (u2) patches and writes the next (u0) patch.
- At the end of the step it rotates the patch roles, so no data is ever copied.
- Sits between the audio-rate step trigger and the memory; it also exports one node as the audio sample.

---
 rtl/patch_step_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/patch_step_sequencer.sv
`default_nettype none
// patch_step_sequencer: one finite-difference time step of a 16-node fixed-end string per start
// pulse, streaming through a three-patch node memory and rotating patch roles at the end of the step.
module patch_step_sequencer #(
  parameter int RHO_SHIFT   = 4,
  parameter int ETA_SHIFT   = 10,
  parameter int SAMPLE_NODE = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        step_done,
  output logic [1:0]  mem_patch,
  output logic [3:0]  mem_addr,
  output logic        mem_we,
  output logic [17:0] mem_wdata,
  input  logic [17:0] mem_rdata,
  output logic [17:0] sample_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_RD_R  = 3'd2,
    S_RD_P  = 3'd3,
    S_WR    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [3:0] C_SAMPLE_NODE = 4'(SAMPLE_NODE);
  localparam logic signed [20:0] C_SAT_MAX = 21'sd131071;
  localparam logic signed [20:0] C_SAT_MIN = -21'sd131072;

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_i;
  logic [17:0]        r_left, r_center, r_right, r_sample;
  logic [1:0]         r_next, r_cur, r_prev;

  logic signed [20:0] w_l, w_c, w_r, w_p;
  logic signed [20:0] w_lap, w_a, w_d, w_sum;
  logic [17:0]        w_res;

  // 21-bit sign-extended window; in WR the memory output is u2[i]
  assign w_l   = {{3{r_left[17]}}, r_left};
  assign w_c   = {{3{r_center[17]}}, r_center};
  assign w_r   = {{3{r_right[17]}}, r_right};
  assign w_p   = {{3{mem_rdata[17]}}, mem_rdata};
  assign w_lap = w_l + w_r - (w_c <<< 1);
  assign w_a   = (w_c <<< 1) - w_p;
  assign w_d   = (w_c - w_p) >>> ETA_SHIFT;
  assign w_sum = w_a + (w_lap >>> RHO_SHIFT) - w_d;

  always_comb begin
    w_res = w_sum[17:0];
    if (w_sum > C_SAT_MAX) begin
      w_res = C_SAT_MAX[17:0];
    end else if (w_sum < C_SAT_MIN) begin
      w_res = C_SAT_MIN[17:0];
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign sample_out = r_sample;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_patch   = 2'd0;
    mem_addr    = 4'd0;
    mem_we      = 1'b0;
    mem_wdata   = 18'd0;
    step_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_PRIME;
      end
      S_PRIME: begin
        mem_patch   = r_cur;
        w_state_nxt = S_RD_R;
      end
      S_RD_R: begin
        mem_patch   = r_cur;
        mem_addr    = r_i + 4'd1;
        w_state_nxt = S_RD_P;
      end
      S_RD_P: begin
        mem_patch   = r_prev;
        mem_addr    = r_i;
        w_state_nxt = S_WR;
      end
      S_WR: begin
        mem_patch   = r_next;
        mem_addr    = r_i;
        mem_we      = 1'b1;
        mem_wdata   = w_res;
        w_state_nxt = (r_i == 4'd15) ? S_DONE : S_RD_R;
      end
      S_DONE: begin
        step_done   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i      <= 4'd0;
      r_left   <= 18'd0;
      r_center <= 18'd0;
      r_right  <= 18'd0;
      r_sample <= 18'd0;
      r_next   <= 2'd0;
      r_cur    <= 2'd1;
      r_prev   <= 2'd2;
    end else begin
      case (r_state)
        S_PRIME: r_left <= 18'd0;
        S_RD_R: begin
          if (r_i == 4'd0) r_center <= mem_rdata;
        end
        S_RD_P: r_right <= (r_i == 4'd15) ? 18'd0 : mem_rdata;
        S_WR: begin
          r_left   <= r_center;
          r_center <= r_right;
          if (r_i == C_SAMPLE_NODE) r_sample <= w_res;
          r_i <= (r_i == 4'd15) ? 4'd0 : r_i + 4'd1;
        end
        S_DONE: begin
          // the just-written patch becomes current; the old current becomes previous
          r_next <= r_prev;
          r_cur  <= r_next;
          r_prev <= r_cur;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
